// File: rtl/dmem_mmio_responder.sv
// Data-memory target: word-addressed RAM plus an MMIO window holding a cycle counter
// and a byte-wide console TX FIFO drained over a valid/ready handshake.
module dmem_mmio_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned RamDepth = 2 ** ADDR_WIDTH;

    logic [31:0]     ram_q [RamDepth];
    logic [31:0]     cycle_q, cycle_d;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    logic ram_hit, sel_cycle, sel_txdata, sel_status;
    logic full, empty, pop, push_req, push, overflow, clr_ovf;

    assign ram_hit    = (address_dmem >> ADDR_WIDTH) == 32'd0;
    assign sel_cycle  = address_dmem == MMIO_BASE;
    assign sel_txdata = address_dmem == MMIO_BASE + 32'd1;
    assign sel_status = address_dmem == MMIO_BASE + 32'd2;

    assign full     = count_q == CntW'(FIFO_DEPTH);
    assign empty    = count_q == '0;
    assign tx_valid = !empty;
    assign tx_data  = fifo_q[rd_ptr_q];

    assign pop      = tx_valid && tx_ready;
    assign push_req = wren && sel_txdata;
    // A push into a full FIFO is legal when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign overflow = push_req && full && !pop;
    assign clr_ovf  = wren && sel_status && data[9];

    always_comb begin
        cycle_d  = (wren && sel_cycle) ? data : cycle_q + 32'd1;
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
        // Overflow takes priority over a clear on the same edge.
        ovf_d = overflow || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= data[7:0];
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (wren && ram_hit) begin
            ram_q[address_dmem[ADDR_WIDTH-1:0]] <= data;
        end
    end

    always_comb begin
        q_dmem = '0;
        if (ram_hit) begin
            q_dmem = ram_q[address_dmem[ADDR_WIDTH-1:0]];
        end else if (sel_cycle) begin
            q_dmem = cycle_q;
        end else if (sel_status) begin
            q_dmem = {22'b0, ovf_q, full, empty, 7'(count_q)};
        end
    end

endmodule
